// File: rtl/snitch_icache_refill_coalescer.sv
// snitch_icache_refill_coalescer
// Tracks outstanding L0 line refills in an in-order table in front of the L1 refill
// handler. Responses from L1 pass straight through to L0 with the ID mask of the
// head entry.
// Optional feature macro: SNITCH_ICACHE_COALESCE_EN. When it is defined, a request for a
// line already in the table merges its ID into that entry and does not cost another L1
// access. When it is undefined, every request allocates and the block is a plain
// in-order tracking FIFO.
module snitch_icache_refill_coalescer #(
    parameter int unsigned FETCH_AW   = 32,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [FETCH_AW-1:0]   in_req_addr_i,
    input  logic [ID_WIDTH-1:0]   in_req_id_i,
    input  logic                  in_req_valid_i,
    output logic                  in_req_ready_o,
    output logic [FETCH_AW-1:0]   out_req_addr_o,
    output logic [ID_WIDTH-1:0]   out_req_id_o,
    output logic                  out_req_valid_o,
    input  logic                  out_req_ready_i,
    input  logic [LINE_WIDTH-1:0] out_rsp_data_i,
    input  logic                  out_rsp_error_i,
    input  logic                  out_rsp_valid_i,
    output logic                  out_rsp_ready_o,
    output logic [LINE_WIDTH-1:0] in_rsp_data_o,
    output logic                  in_rsp_error_o,
    output logic [ID_WIDTH-1:0]   in_rsp_id_o,
    output logic                  in_rsp_valid_o,
    input  logic                  in_rsp_ready_i
);

    localparam int unsigned LINE_ALIGN = $clog2(LINE_WIDTH / 8);
    localparam int unsigned TAG_W      = FETCH_AW - LINE_ALIGN;
    localparam int unsigned PTR_W      = $clog2(DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic                vld;
        logic [TAG_W-1:0]    tag;
        logic [ID_WIDTH-1:0] alloc_id;
        logic [ID_WIDTH-1:0] id_mask;
    } entry_t;

    localparam cnt_t FULL = cnt_t'(DEPTH);

    entry_t [DEPTH-1:0] entries;
    ptr_t               head;
    ptr_t               send;
    ptr_t               tail;
    cnt_t               count;
    // Entries allocated but not yet issued. With the table full, send == tail holds both
    // when nothing and when everything has been issued, so the issue side keeps its own
    // count instead of comparing pointers.
    cnt_t               pend;

    logic [TAG_W-1:0]   line_tag;
    logic               match;
    ptr_t               match_idx;
    logic               req_fire;
    logic               alloc;
    logic               merge;
    logic               issue;
    logic               pop;

    assign line_tag = in_req_addr_i[FETCH_AW-1:LINE_ALIGN];

    // Tag lookup over the valid entries, lowest index wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path
        //       leaves it unassigned and no latch is inferred.
        match     = 1'b0;
        match_idx = '0;
`ifdef SNITCH_ICACHE_COALESCE_EN
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entries[i].vld && (entries[i].tag == line_tag)) begin
                match     = 1'b1;
                match_idx = ptr_t'(i);
            end
        end
`endif
    end

    // A request that hits the head entry while that entry is popping is still merged:
    // its ID rides on the outgoing response, so no second L1 access is made. The head
    // is therefore never dropped from the lookup, and in_req_ready_o does not depend on
    // in_rsp_ready_i.
    assign in_req_ready_o  = (count != FULL) | match;
    assign req_fire        = in_req_valid_i & in_req_ready_o;
    assign alloc           = req_fire & ~match;
    assign merge           = req_fire & match;

    assign out_req_valid_o = (pend != '0);
    assign out_req_addr_o  = {entries[send].tag, {LINE_ALIGN{1'b0}}};
    assign out_req_id_o    = entries[send].alloc_id;
    assign issue           = out_req_valid_o & out_req_ready_i;

    assign in_rsp_valid_o  = out_rsp_valid_i & (count != '0);
    assign out_rsp_ready_o = in_rsp_ready_i;
    assign in_rsp_data_o   = out_rsp_data_i;
    assign in_rsp_error_o  = out_rsp_error_i;
    assign pop             = out_rsp_valid_i & in_rsp_ready_i & (count != '0);

`ifdef SNITCH_ICACHE_COALESCE_EN
    assign in_rsp_id_o = entries[head].id_mask
                       | ((merge && (match_idx == head)) ? in_req_id_i : '0);
`else
    assign in_rsp_id_o = entries[head].alloc_id;

    // Without coalescing nothing looks up the table or grows a mask, so the valid bits
    // and masks are bookkeeping only.
    logic [DEPTH-1:0] unused_vld;
    logic [DEPTH-1:0] unused_mask;
    // Collect the bookkeeping-only fields.
    always_comb begin
        unused_vld  = '0;
        unused_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            unused_vld[i]  = entries[i].vld;
            unused_mask[i] = ^entries[i].id_mask;
        end
    end
`endif

    // Line offset bits never reach L1; requests are always line aligned.
    logic unused_offset;
    assign unused_offset = ^in_req_addr_i[LINE_ALIGN-1:0];

    // Table, pointers and counters, all under synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // NOTE: the table is only DEPTH entries and its fields drive out_req_* directly,
            //       so it is reset like any other register rather than treated as a RAM.
            entries <= '0;
            head    <= '0;
            send    <= '0;
            tail    <= '0;
            count   <= '0;
            pend    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every update below see the pre-edge
            //       state, independent of statement order.
            if (merge) begin
                entries[match_idx].id_mask <= entries[match_idx].id_mask | in_req_id_i;
            end
            if (alloc) begin
                entries[tail].vld      <= 1'b1;
                entries[tail].tag      <= line_tag;
                entries[tail].alloc_id <= in_req_id_i;
                entries[tail].id_mask  <= in_req_id_i;
                tail                   <= tail + ptr_t'(1);
            end
            if (issue) begin
                send <= send + ptr_t'(1);
            end
            if (pop) begin
                entries[head].vld <= 1'b0;
                head              <= head + ptr_t'(1);
            end
            case ({alloc, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
            case ({alloc, issue})
                2'b10:   pend <= pend + cnt_t'(1);
                2'b01:   pend <= pend - cnt_t'(1);
                default: pend <= pend;
            endcase
        end
    end

    // L1 may only respond while at least one issued request is outstanding.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_rsp_valid_i |-> ((count != '0) && (count != pend)));

endmodule

// File: tb/tb_snitch_icache_refill_coalescer.sv
// Self-checking bench for snitch_icache_refill_coalescer (default parameters).
// A queue-based reference model tracks outstanding lines; directed scenarios are
// followed by a randomized phase. Expectations follow SNITCH_ICACHE_COALESCE_EN.
module tb_snitch_icache_refill_coalescer;

    localparam int DEPTH = 4;
`ifdef SNITCH_ICACHE_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  req_addr;
    logic [1:0]   req_id;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  oreq_addr;
    logic [1:0]   oreq_id;
    logic         oreq_valid;
    logic         oreq_ready;
    logic [127:0] orsp_data;
    logic         orsp_error;
    logic         orsp_valid;
    logic         orsp_ready;
    logic [127:0] irsp_data;
    logic         irsp_error;
    logic [1:0]   irsp_id;
    logic         irsp_valid;
    logic         irsp_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    snitch_icache_refill_coalescer dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .in_req_addr_i   (req_addr),
        .in_req_id_i     (req_id),
        .in_req_valid_i  (req_valid),
        .in_req_ready_o  (req_ready),
        .out_req_addr_o  (oreq_addr),
        .out_req_id_o    (oreq_id),
        .out_req_valid_o (oreq_valid),
        .out_req_ready_i (oreq_ready),
        .out_rsp_data_i  (orsp_data),
        .out_rsp_error_i (orsp_error),
        .out_rsp_valid_i (orsp_valid),
        .out_rsp_ready_o (orsp_ready),
        .in_rsp_data_o   (irsp_data),
        .in_rsp_error_o  (irsp_error),
        .in_rsp_id_o     (irsp_id),
        .in_rsp_valid_o  (irsp_valid),
        .in_rsp_ready_i  (irsp_ready)
    );

    // Reference model: outstanding lines oldest first; the first sent_n are issued.
    typedef struct {
        logic [31:0] line;
        logic [1:0]  aid;
        logic [1:0]  mask;
    } ent_t;

    ent_t mq[$];
    int   sent_n = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Index of the outstanding entry holding this line, or -1.
    function automatic int find(input logic [31:0] addr);
        int k = -1;
        if (COALESCE) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].line == {addr[31:4], 4'h0}) k = i;
            end
        end
        return k;
    endfunction

    task automatic drive(input logic rv, input logic [31:0] ra, input logic [1:0] rid,
                         input logic oqr, input logic sv, input logic [127:0] sd,
                         input logic se, input logic sr);
        @(negedge clk);
        req_valid  = rv;
        req_addr   = ra;
        req_id     = rid;
        oreq_ready = oqr;
        orsp_valid = sv;
        orsp_data  = sd;
        orsp_error = se;
        irsp_ready = sr;
        #1;
    endtask

    task automatic check_model();
        int n = mq.size();
        int k = find(req_addr);
        logic [1:0] exp_id;
        check("in_req_ready", req_ready, (n != DEPTH) || (k >= 0));
        check("out_req_valid", oreq_valid, sent_n < n);
        if (sent_n < n) begin
            check("out_req_addr", oreq_addr, mq[sent_n].line);
            check("out_req_id", oreq_id, mq[sent_n].aid);
        end
        check("out_rsp_ready", orsp_ready, irsp_ready);
        check("in_rsp_valid", irsp_valid, orsp_valid && (n != 0));
        if (orsp_valid && (n != 0)) begin
            exp_id = mq[0].mask | ((req_valid && (k == 0)) ? req_id : 2'b00);
            check("in_rsp_data", irsp_data, orsp_data);
            check("in_rsp_error", irsp_error, orsp_error);
            check("in_rsp_id", irsp_id, exp_id);
        end
    endtask

    task automatic commit();
        int n;
        int k;
        bit rdy;
        bit pop;
        bit iss;
        ent_t e;
        @(posedge clk);
        n   = mq.size();
        k   = find(req_addr);
        rdy = (n != DEPTH) || (k >= 0);
        pop = orsp_valid && irsp_ready && (n != 0);
        iss = (sent_n < n) && oreq_ready;
        if (req_valid && rdy) begin
            if (k >= 0) begin
                e      = mq[k];
                e.mask = e.mask | req_id;
                mq[k]  = e;
            end else begin
                mq.push_back('{line: {req_addr[31:4], 4'h0}, aid: req_id, mask: req_id});
            end
        end
        if (iss) sent_n++;
        if (pop) begin
            void'(mq.pop_front());
            sent_n--;
        end
    endtask

    task automatic step(input logic rv, input logic [31:0] ra, input logic [1:0] rid,
                        input logic oqr, input logic sv, input logic [127:0] sd,
                        input logic se, input logic sr);
        drive(rv, ra, rid, oqr, sv, sd, se, sr);
        check_model();
        commit();
    endtask

    // Issue and answer everything outstanding, bounded by a cycle budget.
    task automatic drain();
        for (int i = 0; (i < 3 * DEPTH) && (mq.size() != 0); i++) begin
            step(1'b0, 32'h0, 2'b00, 1'b1, sent_n > 0, rand128(), 1'b0, 1'b1);
        end
        check("drain_budget", 128'(mq.size()), 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_id     = '0;
        oreq_ready = 1'b0;
        orsp_valid = 1'b0;
        orsp_data  = '0;
        orsp_error = 1'b0;
        irsp_ready = 1'b0;
        @(negedge clk);
        #1;
        mq.delete();
        sent_n = 0;
        check("reset_in_req_ready", req_ready, 1'b1);
        check("reset_out_req_valid", oreq_valid, 1'b0);
        check("reset_out_req_addr", oreq_addr, 32'h0);
        check("reset_out_req_id", oreq_id, 2'b00);
        check("reset_in_rsp_id", irsp_id, 2'b00);
        check("reset_in_rsp_valid", irsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [127:0] d;
        logic [31:0]  a;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_id     = '0;
        oreq_ready = 1'b0;
        orsp_valid = 1'b0;
        orsp_data  = '0;
        orsp_error = 1'b0;
        irsp_ready = 1'b0;
        do_reset();

        // Single miss: issued the cycle after accept, response passes through.
        step(1'b1, 32'h1004, 2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("miss_out_req_valid", oreq_valid, 1'b1);
        check("miss_out_req_addr", oreq_addr, 32'h1000);
        check("miss_out_req_id", oreq_id, 2'b01);
        check_model();
        commit();
        d = rand128();
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, d, 1'b0, 1'b1);
        check("miss_rsp_valid", irsp_valid, 1'b1);
        check("miss_rsp_data", irsp_data, d);
        check("miss_rsp_id", irsp_id, 2'b01);
        check_model();
        commit();

        // Two requests to one line before any response.
        step(1'b1, 32'h2000, 2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 32'h2008, 2'b10, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("coal_first_id", oreq_id, 2'b01);
        check_model();
        commit();
        drive(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("coal_second_req", oreq_valid, !COALESCE);
        check_model();
        commit();
        d = rand128();
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, d, 1'b0, 1'b1);
        check("coal_rsp_id", irsp_id, COALESCE ? 2'b11 : 2'b01);
        check_model();
        commit();
        drain();

        // Fill with four distinct lines while L1 stalls requests.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h3000 + 16 * i, 2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        end
        drive(1'b1, 32'h3040, 2'b10, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("full_ready_distinct", req_ready, 1'b0);
        check("full_out_req_valid", oreq_valid, 1'b1);
        check_model();
        commit();
        drive(1'b1, 32'h3014, 2'b10, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("full_ready_match", req_ready, COALESCE);
        check_model();
        commit();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b1);
            check($sformatf("full_drain_addr%0d", i), oreq_addr, 32'h3000 + 16 * i);
            check_model();
            commit();
        end
        drain();

        // Request hits the head in the cycle the head's response completes.
        step(1'b1, 32'h4000, 2'b01, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        d = rand128();
        drive(1'b1, 32'h4004, 2'b10, 1'b0, 1'b1, d, 1'b0, 1'b1);
        check("bnd_pop_ready", req_ready, 1'b1);
        check("bnd_pop_rsp_id", irsp_id, COALESCE ? 2'b11 : 2'b01);
        check_model();
        commit();
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("bnd_pop_alloc", oreq_valid, !COALESCE);
        check_model();
        commit();
        drain();

        // Same hit with the response stalled, then held, then released.
        step(1'b1, 32'h5000, 2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        d = rand128();
        drive(1'b1, 32'h5008, 2'b10, 1'b0, 1'b1, d, 1'b1, 1'b0);
        check("stall_out_rsp_ready", orsp_ready, 1'b0);
        check("stall_rsp_id", irsp_id, COALESCE ? 2'b11 : 2'b01);
        check_model();
        commit();
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, d, 1'b1, 1'b0);
        check("stall_hold_valid", irsp_valid, 1'b1);
        check_model();
        commit();
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, d, 1'b1, 1'b1);
        check("stall_release_id", irsp_id, COALESCE ? 2'b11 : 2'b01);
        check("stall_release_error", irsp_error, 1'b1);
        check_model();
        commit();
        drive(1'b0, 32'h0, 2'b00, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("stall_single_pop", oreq_valid, !COALESCE);
        check_model();
        commit();
        drain();

        // Ten sequential distinct lines walk every pointer around the table.
        for (int i = 0; i < 10; i++) begin
            a = 32'h6000 + 32 * i + 4;
            step(1'b1, a, (i % 2 == 1) ? 2'b10 : 2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b1);
            step(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b1);
            step(1'b0, 32'h0, 2'b00, 1'b0, 1'b1, rand128(), 1'($unsigned(i) & 1), 1'b1);
        end

        // Randomized traffic over a small set of lines.
        for (int c = 0; c < 400; c++) begin
            a = 32'h7000 + 32'($urandom_range(0, 5)) * 16 + 32'($urandom_range(0, 3)) * 4;
            step(rbit(), a, 2'($urandom_range(1, 3)), rbit(),
                 (sent_n > 0) && rbit(), rand128(), rbit(), rbit());
        end
        drain();

        // Reset in the middle of traffic drops every entry.
        step(1'b1, 32'h8000, 2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 32'h8010, 2'b10, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        do_reset();
        step(1'b1, 32'h9000, 2'b01, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("post_reset_addr", oreq_addr, 32'h9000);
        check_model();
        commit();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
